// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port synchronous RAM with request handshake, byte-enable writes, registered reads and a clear/fill sweep engine
module ram_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                rw,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   out,
  output logic                out_valid,
  input  logic                fill_start,
  input  logic [DATA_W-1:0]   fill_data,
  output logic                busy
);
  typedef enum logic [1:0] {CLEAR, IDLE, FILL} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic acc;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign acc = req_valid && req_ready;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (fill_start ? FILL : IDLE) : (&cnt ? IDLE : state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
      out <= '0;
      out_valid <= 1'b0;
      fill_q <= '0;
    end else begin
      state <= state_n;
      cnt <= busy ? cnt + ADDR_W'(1) : '0;
      out_valid <= acc && !rw;
      if (acc && !rw) out <= mem[addr];
      if (req_ready && fill_start) fill_q <= fill_data;
    end
  end
  always_ff @(posedge clk) begin
    if (busy) mem[cnt] <= state == FILL ? fill_q : '0;
    else if (acc && rw)
      for (int k = 0; k < DATA_W/8; k++)
        if (be[k]) mem[addr][8*k +: 8] <= din[8*k +: 8];
  end
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: table-driven and randomized checks of ram_ctrl against a sweep-countdown reference model
module tb_ram_ctrl;
  logic clk = 1'b0;
  logic rst_n, req_valid, rw, fill_start, req_ready, out_valid, busy;
  logic [6:0] addr;
  logic [31:0] din, fill_data, out;
  logic [3:0] be;
  int n_err = 0, n_chk = 0;
  logic [31:0] ref_mem [128];
  int busy_left;
  logic [31:0] pat, exp_out;
  logic exp_ov;
  typedef struct {
    logic rw;
    logic [6:0] addr;
    logic [31:0] din;
    logic [3:0] be;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [9];
  ram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .rw(rw), .addr(addr), .din(din), .be(be), .out(out), .out_valid(out_valid),
    .fill_start(fill_start), .fill_data(fill_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    busy_left = 128;
    pat = '0;
    exp_out = '0;
    exp_ov = 1'b0;
  endtask
  task automatic step();
    logic v, w, fs;
    logic [6:0] a;
    logic [31:0] d, fd;
    logic [3:0] b;
    v = req_valid; w = rw; fs = fill_start; a = addr; d = din; fd = fill_data; b = be;
    chk("req_ready", 32'(req_ready), 32'(busy_left == 0));
    @(posedge clk);
    exp_ov = 1'b0;
    if (busy_left != 0) begin
      ref_mem[128 - busy_left] = pat;
      busy_left--;
    end else begin
      if (v && w) begin
        for (int k = 0; k < 4; k++) if (b[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
      end else if (v) begin
        exp_out = ref_mem[a];
        exp_ov = 1'b1;
      end
      if (fs) begin
        busy_left = 128;
        pat = fd;
      end
    end
    #1;
    chk("out", out, exp_out);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("busy", 32'(busy), 32'(busy_left != 0));
  endtask
  task automatic rd0(input logic [6:0] a, input string name);
    req_valid = 1'b1; rw = 1'b0; addr = a;
    step();
    chk(name, out, 32'h0);
    chk({name, "_ov"}, 32'(out_valid), 32'h1);
    req_valid = 1'b0;
  endtask
  task automatic run_clear(input string name);
    int n;
    for (n = 0; n < 300 && busy; n++) step();
    chk(name, 32'(n), 32'd128);
  endtask
  initial begin
    int n, nv;
    vt[0] = '{1'b0, 7'd0,   32'h0,        4'h0, 32'h0};
    vt[1] = '{1'b0, 7'd64,  32'h0,        4'h0, 32'h0};
    vt[2] = '{1'b0, 7'd127, 32'h0,        4'h0, 32'h0};
    vt[3] = '{1'b1, 7'd5,   32'hDEADBEEF, 4'hF, 32'h0};
    vt[4] = '{1'b0, 7'd5,   32'h0,        4'h0, 32'hDEADBEEF};
    vt[5] = '{1'b1, 7'd5,   32'h11223344, 4'h5, 32'h0};
    vt[6] = '{1'b0, 7'd5,   32'h0,        4'h0, 32'hDE22BE44};
    vt[7] = '{1'b1, 7'd5,   32'hFFFFFFFF, 4'h0, 32'h0};
    vt[8] = '{1'b0, 7'd5,   32'h0,        4'h0, 32'hDE22BE44};
    rst_n = 1'b0; req_valid = 1'b0; rw = 1'b0; fill_start = 1'b0;
    addr = '0; din = '0; fill_data = '0; be = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 32'h0);
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    run_clear("clear_len");
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1; rw = vt[i].rw; addr = vt[i].addr; din = vt[i].din; be = vt[i].be;
      step();
      if (!vt[i].rw) chk("vec_rd", out, vt[i].exp);
      chk("vec_ov", 32'(out_valid), 32'(!vt[i].rw));
    end
    req_valid = 1'b1; rw = 1'b1; addr = 7'd3; din = 32'h12345678; be = 4'hF;
    fill_start = 1'b1; fill_data = 32'hA5A5A5A5;
    step();
    n = busy ? 1 : 0;
    rw = 1'b0; fill_data = 32'h5A5A5A5A;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy) n++;
    end
    fill_start = 1'b0;
    while (busy && n < 300) begin
      step();
      if (busy) n++;
    end
    chk("fill_len", 32'(n), 32'd128);
    step();
    chk("fill_a3", out, 32'hA5A5A5A5);
    chk("fill_a3_ov", 32'(out_valid), 32'h1);
    addr = 7'd127;
    step();
    chk("fill_a127", out, 32'hA5A5A5A5);
    req_valid = 1'b0;
    fill_start = 1'b1; fill_data = 32'hC3C3C3C3;
    step();
    fill_start = 1'b0;
    repeat (40) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out", out, 32'h0);
    chk("midrst_ov", 32'(out_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h1);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_clear("reclear_len");
    rd0(7'd0, "reclr_a0");
    rd0(7'd39, "reclr_a39");
    rd0(7'd100, "reclr_a100");
    for (int a = 0; a < 128; a++) begin
      req_valid = 1'b1; rw = 1'b1; addr = 7'(a); din = $urandom; be = 4'($urandom_range(0, 15));
      step();
    end
    nv = 0;
    for (int a = 0; a < 128; a++) begin
      rw = 1'b0; addr = 7'(a);
      step();
      if (out_valid) nv++;
    end
    chk("throughput", 32'(nv), 32'd128);
    for (int i = 0; i < 600; i++) begin
      req_valid = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      addr = 7'($urandom_range(0, 127)); din = $urandom; be = 4'($urandom_range(0, 15));
      fill_start = $urandom_range(0, 199) == 0; fill_data = $urandom;
      step();
    end
    req_valid = 1'b0; fill_start = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Parametrised single-port synchronous RAM with a request handshake, byte-enable writes, registered read data with a valid strobe, and a hardware clear/fill engine.
- Successor to the fixed 32-bit, 128-word RAM.
- Sits between the CPU datapath and storage; the datapath must wait on req_ready/busy instead of assuming fixed timing.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 7, address width; DEPTH = 2^ADDR_W words (default 128).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  access request present.
- req_ready  output  1  controller accepts a request this cycle.
- rw  input  1  1 = write, 0 = read; sampled on accept.
- addr  input  ADDR_W  word address; sampled on accept.
- din  input  DATA_W  write data.
- be  input  DATA_W/8  byte enables; bit k enables din[8k+7:8k].
- out  output  DATA_W  read data, registered.
- out_valid  output  1  one-cycle strobe: out holds new read data.
- fill_start  input  1  start a fill of the whole array with fill_data.
- fill_data  input  DATA_W  fill pattern; captured at fill_start.
- busy  output  1  high while clearing or filling.

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rst_n.
- Reset asserted:
  - state = CLEAR, counter = 0.
  - out = 0, out_valid = 0.
  - busy = 1, req_ready = 0.
  - Array contents are not reset directly; CLEAR overwrites them.
- FSM states: CLEAR, IDLE, FILL. busy = (state != IDLE). req_ready = (state == IDLE), combinational decode of state only.
- CLEAR:
  - Each cycle writes 0 to address counter, then counter increments.
  - After writing DEPTH-1, counter wraps to 0 and state moves to IDLE on the next edge.
  - Duration: exactly DEPTH cycles after rst_n deasserts.
- IDLE, an accept occurs when req_valid && req_ready:
  - Write (rw = 1): each byte with be[k] = 1 takes din; other bytes keep their contents. be = 0 is a legal no-op write.
  - Read (rw = 0): out takes mem[addr] on the accepting edge. out_valid = 1 for exactly the following cycle.
- out keeps its value between reads; out_valid = 0 when no read was accepted on the previous edge.
- Accesses can be back-to-back, one per cycle.
- A read accepted the cycle after a write to the same address returns the written data.
- A write does not drive out.
- fill_start in IDLE:
  - fill_data is captured; the next state is FILL with counter = 0.
  - If a request is accepted in the same cycle, that request completes normally. A write in that cycle is later overwritten by the fill.
- fill_start outside IDLE is ignored.
- FILL: the same sweep as CLEAR, but writes the captured fill_data; DEPTH cycles, then IDLE.
- No request is accepted during CLEAR or FILL. A held req_valid waits and is accepted on the first IDLE cycle.
- rst_n asserted mid-fill or mid-clear: immediate return to CLEAR with counter = 0; a full clear follows.
- Counter is ADDR_W bits and wraps naturally. The DEPTH-1 write is the terminal condition, with no extra cycle.
- Addresses are always in range, since DEPTH = 2^ADDR_W.

Test Plan:
- Reset/clear: rst_n low 3 cycles, then high -> busy and !req_ready for exactly 128 cycles. Reads of addr 0, 64 and 127 then return 0x00000000 with out_valid one cycle after accept.
- Write/read: write 0xDEADBEEF to addr 5 (be = 4'hF); read addr 5 the next cycle -> out = 0xDEADBEEF with a single-cycle out_valid, one cycle after the read accept.
- Byte enables: over 0xDEADBEEF at addr 5, write 0x11223344 with be = 4'b0101 -> read returns 0xDE22BE44. With be = 4'b0000 -> unchanged.
- Fill with collision:
  - Stimulus: fill_start with fill_data = 0xA5A5A5A5 in the same cycle as an accepted write of 0x12345678 to addr 3.
  - Required: busy high for 128 cycles and req_ready low throughout.
  - Required: a held read request is accepted on the first IDLE cycle; addr 3 and addr 127 then read 0xA5A5A5A5.
  - Required: fill_start asserted during FILL has no effect.
- Reset mid-fill: assert rst_n at fill cycle 40 -> out = 0 and out_valid = 0 immediately. After release, a 128-cycle clear runs and addrs 0, 39 and 100 read 0.
- Random sweep: for addr 0..127, write $urandom with random be, then read back each address -> every read matches the scoreboard model. Check back-to-back read/write throughput of one access per cycle.
